// File: rtl/decode_pkg.sv
// decode_pkg: format/opcode constants and immediate extension shared by the decode stage
//   FMT_*      : 2-bit format codes driven on out_fmt
//   OP_J*/R_LIM: opcode classification constants
//   ext_imm    : sign/zero-extend the low imm_w bits of raw to 64 bits
package decode_pkg;
    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_I = 2'd1;
    localparam logic [1:0] FMT_J = 2'd2;
    localparam int unsigned OP_J0 = 12;
    localparam int unsigned OP_J1 = 13;
    localparam int unsigned OP_J2 = 14;
    localparam int unsigned R_LIM = 9;

    // Left-align the field so its sign bit lands in bit 63, then shift back.
    function automatic logic [63:0] ext_imm(input logic [63:0] raw, input int imm_w, input logic sext);
        logic [63:0] v;
        logic signed [63:0] s;
        v = raw << (64 - imm_w);
        s = $signed(v);
        s = s >>> (64 - imm_w);
        return sext ? s : v >> (64 - imm_w);
    endfunction
endpackage

// File: rtl/decode_skid_buf.sv
// decode_skid_buf: 2-entry valid/ready FIFO of W-bit records with synchronous flush
//   i_valid/o_ready/i_data : upstream handshake (o_ready independent of i_ready)
//   o_valid/i_ready/o_data : downstream handshake, o_data is the head entry
//   i_flush                : empty the buffer at the next edge, blocks enqueue
module decode_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);
    logic [W-1:0] r_mem [2];
    logic         r_wp;
    logic         r_rp;
    logic [1:0]   r_cnt;
    logic         w_enq;
    logic         w_deq;

    assign o_ready = (r_cnt != 2'd2) && !i_flush;
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_mem[r_rp];
    assign w_enq   = i_valid && o_ready;
    assign w_deq   = o_valid && i_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= 2'd0;
        end else if (i_flush) begin
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_enq) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= ~r_wp;
            end
            if (w_deq)
                r_rp <= ~r_rp;
            r_cnt <= r_cnt + 2'(w_enq) - 2'(w_deq);
        end
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode with 2-entry buffering, flush and dequeue counter
//   in_valid/in_ready/in_instr : raw instruction handshake
//   flush                      : discard buffered and incoming words
//   out_valid/out_ready/out_*  : decoded head entry handshake
//   decode_count               : saturating count of dequeued entries
module decode_stage
    import decode_pkg::*;
#(
    parameter int OPC_W    = 4,
    parameter int REG_W    = 3,
    parameter int IMM_W    = 6,
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 16,
    parameter int DATA_W   = 8,
    parameter int IMM_SEXT = 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   out_opcode,
    output logic [1:0]         out_fmt,
    output logic [REG_W-1:0]   out_rs1,
    output logic [REG_W-1:0]   out_rs2,
    output logic [REG_W-1:0]   out_rd,
    output logic [DATA_W-1:0]  out_imm,
    output logic [ADDR_W-1:0]  out_jmp_addr,
    output logic [CNT_W-1:0]   decode_count
);
    localparam int T     = INSTR_W - 1;
    localparam int REC_W = OPC_W + 2 + 3 * REG_W + DATA_W + ADDR_W;

    if (INSTR_W < OPC_W + 3 * REG_W || INSTR_W < OPC_W + 2 * REG_W + IMM_W ||
        INSTR_W < OPC_W + ADDR_W || DATA_W < IMM_W || DATA_W > 64 || IMM_W < 1) begin : g_bad_params
        $fatal(1, "decode_stage: illegal parameter combination");
    end

    logic [OPC_W-1:0]  w_op;
    logic              w_is_j;
    logic              w_is_r;
    logic [REG_W-1:0]  w_f1;
    logic [REG_W-1:0]  w_f2;
    logic [REG_W-1:0]  w_f3;
    logic [1:0]        w_fmt;
    logic [REG_W-1:0]  w_rs1;
    logic [REG_W-1:0]  w_rs2;
    logic [REG_W-1:0]  w_rd;
    logic [DATA_W-1:0] w_imm;
    logic [ADDR_W-1:0] w_jmp;
    logic [REC_W-1:0]  w_in_rec;
    logic [REC_W-1:0]  w_out_rec;
    logic              w_deq;
    logic [CNT_W-1:0]  r_cnt;

    assign w_op   = in_instr[T -: OPC_W];
    assign w_f1   = in_instr[T-OPC_W -: REG_W];
    assign w_f2   = in_instr[T-OPC_W-REG_W -: REG_W];
    assign w_f3   = in_instr[T-OPC_W-2*REG_W -: REG_W];
    assign w_is_j = 32'(w_op) == OP_J0 || 32'(w_op) == OP_J1 || 32'(w_op) == OP_J2;
    // Jump opcodes are never <= R_LIM, so the R test needs no J exclusion.
    assign w_is_r = !w_op[0] && 32'(w_op) <= R_LIM;
    assign w_fmt  = w_is_j ? FMT_J : (w_is_r ? FMT_R : FMT_I);
    assign w_rs1  = w_is_j ? '0 : w_f1;
    assign w_rs2  = w_is_r ? w_f2 : '0;
    assign w_rd   = w_is_r ? w_f3 : (w_is_j ? '0 : w_f2);
    assign w_imm  = (w_is_r || w_is_j) ? '0 : DATA_W'(ext_imm(64'(in_instr[IMM_W-1:0]), IMM_W, IMM_SEXT != 0));
    assign w_jmp  = w_is_j ? in_instr[T-OPC_W -: ADDR_W] : '0;

    assign w_in_rec = {w_op, w_fmt, w_rs1, w_rs2, w_rd, w_imm, w_jmp};
    assign {out_opcode, out_fmt, out_rs1, out_rs2, out_rd, out_imm, out_jmp_addr} = w_out_rec;

    decode_skid_buf #(.W(REC_W)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_in_rec),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_out_rec)
    );

    assign w_deq = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (w_deq && r_cnt != '1)
            r_cnt <= r_cnt + 1'b1;
    end

    assign decode_count = r_cnt;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed + randomized check of decode_stage against a queue-based model
module tb_decode_stage;
    typedef struct packed {
        logic [3:0] op;
        logic [1:0] fmt;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [2:0] rd;
        logic [7:0] imm;
        logic [7:0] jmp;
    } rec_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic [15:0] in_instr = 0;
    logic        flush = 0;
    logic        out_ready = 0;

    logic        a_ready, a_valid, b_ready, b_valid;
    logic [3:0]  a_op, b_op;
    logic [1:0]  a_fmt, b_fmt;
    logic [2:0]  a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;
    logic [7:0]  a_imm, a_jmp, b_imm, b_jmp;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int q[$];
    int n1 = 0;
    int n2 = 0;

    always #5 clk = ~clk;

    decode_stage u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ready), .in_instr(in_instr),
        .flush(flush), .out_valid(a_valid), .out_ready(out_ready), .out_opcode(a_op),
        .out_fmt(a_fmt), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_imm(a_imm),
        .out_jmp_addr(a_jmp), .decode_count(a_cnt)
    );

    decode_stage #(.IMM_SEXT(0), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ready), .in_instr(in_instr),
        .flush(flush), .out_valid(b_valid), .out_ready(out_ready), .out_opcode(b_op),
        .out_fmt(b_fmt), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd), .out_imm(b_imm),
        .out_jmp_addr(b_jmp), .decode_count(b_cnt)
    );

    // Decode a word straight from the field layout with shifts and masks.
    function automatic rec_t model(int w, bit sext);
        rec_t r;
        int op;
        r = '0;
        op = (w >> 12) & 15;
        r.op = 4'(op);
        if (op == 12 || op == 13 || op == 14) begin
            r.fmt = 2'd2;
            r.jmp = 8'((w >> 4) & 255);
        end else if (op % 2 == 0 && op <= 9) begin
            r.fmt = 2'd0;
            r.rs1 = 3'((w >> 9) & 7);
            r.rs2 = 3'((w >> 6) & 7);
            r.rd  = 3'((w >> 3) & 7);
        end else begin
            r.fmt = 2'd1;
            r.rs1 = 3'((w >> 9) & 7);
            r.rd  = 3'((w >> 6) & 7);
            r.imm = 8'((sext && (w & 32) != 0) ? (w & 63) + 192 : (w & 63));
        end
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_dut(string tag, logic v, logic rdy, rec_t act, logic [15:0] cnt, bit sext, int n);
        chk({tag, ".in_ready"}, 32'(rdy), 32'(q.size() < 2 && !flush));
        chk({tag, ".out_valid"}, 32'(v), 32'(q.size() != 0));
        chk({tag, ".decode_count"}, 32'(cnt), 32'(n));
        if (q.size() != 0)
            chk({tag, ".head"}, 32'(act), 32'(model(q[0], sext)));
    endtask

    always @(posedge clk) begin
        if (rst) begin
            q = {};
            n1 = 0;
            n2 = 0;
        end else begin
            automatic bit enq = in_valid && q.size() < 2 && !flush;
            if (q.size() != 0 && out_ready) begin
                void'(q.pop_front());
                if (n1 < 65535) n1++;
                if (n2 < 3) n2++;
            end
            if (flush) q = {};
            else if (enq) q.push_back(int'(in_instr));
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            cmp_dut("a", a_valid, a_ready, {a_op, a_fmt, a_rs1, a_rs2, a_rd, a_imm, a_jmp}, a_cnt, 1'b1, n1);
            cmp_dut("b", b_valid, b_ready, {b_op, b_fmt, b_rs1, b_rs2, b_rd, b_imm, b_jmp}, 16'(b_cnt), 1'b0, n2);
        end
    end

    task automatic step(logic v, logic [15:0] w, logic f, logic r);
        in_valid = v;
        in_instr = w;
        flush = f;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(a_valid), 0);
        chk("rst.in_ready", 32'(a_ready), 1);
        chk("rst.fields", 32'({a_op, a_fmt, a_rs1, a_rs2, a_rd, a_imm, a_jmp}), 0);
        chk("rst.count", 32'(a_cnt), 0);
        @(posedge clk);
        #1 rst = 0;

        step(1, 16'h0A98, 0, 1);
        chk("r.valid", 32'(a_valid), 1);
        chk("r.fields", 32'({a_op, a_fmt, a_rs1, a_rs2, a_rd, a_imm, a_jmp}),
            32'({4'd0, 2'd0, 3'd5, 3'd2, 3'd3, 8'd0, 8'd0}));
        chk("r.count_before", 32'(a_cnt), 0);
        step(0, 16'h0000, 0, 1);
        chk("r.count_after", 32'(a_cnt), 1);
        chk("sat.1", 32'(b_cnt), 1);
        step(1, 16'h1E7E, 0, 1);
        chk("i.fields", 32'({a_fmt, a_rs1, a_rs2, a_rd, a_imm}), 32'({2'd1, 3'd7, 3'd0, 3'd1, 8'hFE}));
        chk("i.zext_imm", 32'(b_imm), 32'h3E);
        step(1, 16'hA000, 0, 1);
        chk("op10.fmt", 32'(a_fmt), 1);
        chk("sat.2", 32'(b_cnt), 2);
        step(1, 16'hC5A0, 0, 1);
        chk("j.fields", 32'({a_op, a_fmt, a_rs1, a_rs2, a_rd, a_imm, a_jmp}),
            32'({4'd12, 2'd2, 3'd0, 3'd0, 3'd0, 8'd0, 8'h5A}));
        chk("sat.3", 32'(b_cnt), 3);
        step(1, 16'hF000, 0, 1);
        chk("op15.fmt", 32'(a_fmt), 1);
        chk("sat.4", 32'(b_cnt), 3);
        step(0, 16'h0000, 0, 1);
        chk("sat.5", 32'(b_cnt), 3);
        chk("cnt16", 32'(a_cnt), 5);

        step(1, 16'h0A98, 0, 0);
        step(1, 16'h1E7E, 0, 0);
        chk("bp.full_ready", 32'(a_ready), 0);
        chk("bp.head", 32'(a_rs1), 5);
        step(1, 16'hC5A0, 0, 0);
        chk("bp.hold", 32'({a_rs1, a_rs2, a_rd}), 32'({3'd5, 3'd2, 3'd3}));
        step(1, 16'hC5A0, 0, 1);
        chk("bp.head2", 32'({a_fmt, a_rs1}), 32'({2'd1, 3'd7}));
        chk("bp.ready2", 32'(a_ready), 1);
        step(1, 16'hC5A0, 0, 1);
        chk("bp.head3", 32'({a_fmt, a_jmp}), 32'({2'd2, 8'h5A}));
        step(0, 16'h0000, 0, 1);

        step(1, 16'h0A98, 0, 0);
        step(1, 16'h1E7E, 0, 0);
        in_valid = 1;
        in_instr = 16'hC5A0;
        flush = 1;
        #1;
        chk("flush.in_ready", 32'(a_ready), 0);
        @(posedge clk);
        #1;
        chk("flush.out_valid", 32'(a_valid), 0);
        chk("flush.count", 32'(a_cnt), 8);
        step(1, 16'h0A98, 0, 0);
        step(1, 16'h1E7E, 0, 0);
        in_valid = 0;
        rst = 1;
        #1;
        chk("arst.out_valid", 32'(a_valid), 0);
        chk("arst.fields", 32'({a_op, a_fmt, a_rs1, a_rs2, a_rd, a_imm, a_jmp}), 0);
        chk("arst.count", 32'(a_cnt), 0);
        @(posedge clk);
        #1 rst = 0;

        for (int i = 0; i < 3000; i++)
            step($urandom % 4 != 0, 16'($urandom), $urandom % 16 == 0, $urandom % 3 != 0);
        step(0, 16'h0000, 0, 1);
        step(0, 16'h0000, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
